// File: rtl/lstm_cell_state.sv
// LSTM cell-state / hidden-output stage: c_t = f*c_{t-1} + i*g, h_t = o*tanh(c_t),
// evaluated over three cycles on one shared saturating Q(WIDTH-FRAC).FRAC multiplier.

// Combinational piecewise-linear tanh, odd-symmetric, continuous at every knee:
// |x|<0.5: x ; <1.25: |x|/2+0.25 ; <2.25: |x|/8+0.71875 ; else 1.0
module lstm_tanh #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  localparam logic [WIDTH:0] ONE = {{(WIDTH-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic [WIDTH:0] T1  = ONE + (ONE >> 2);
  localparam logic [WIDTH:0] T2  = (ONE << 1) + (ONE >> 2);
  localparam logic [WIDTH:0] OFS = (ONE >> 1) + (ONE >> 3) + (ONE >> 4) + (ONE >> 5);

  logic             neg;
  logic [WIDTH:0]   xe;
  logic [WIDTH:0]   mag;
  logic [WIDTH:0]   seg;
  logic [WIDTH:0]   seg_n;

  always_comb begin
    neg   = x[WIDTH-1];
    xe    = {x[WIDTH-1], x};
    // One extra bit so |0x80000000| is representable
    mag   = neg ? (~xe + (WIDTH+1)'(1)) : xe;
    if (mag < (ONE >> 1))   seg = mag;
    else if (mag < T1)      seg = (mag >> 1) + (ONE >> 2);
    else if (mag < T2)      seg = (mag >> 3) + OFS;
    else                    seg = ONE;
    seg_n = ~seg + (WIDTH+1)'(1);
    y     = neg ? seg_n[WIDTH-1:0] : seg[WIDTH-1:0];
  end
endmodule

module lstm_cell_state #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_f,
  input  logic [WIDTH-1:0] i_i,
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_o,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_h,
  output logic [WIDTH-1:0] o_c,
  output logic [WIDTH-1:0] o_c_prev,
  output logic [2:0]       dbg_state
);
  // Handshake: a step is accepted on a rising edge where i_valid & o_ready (IDLE only);
  // results are offered while o_valid (DONE) and consumed on the edge with i_ready high.
  typedef enum logic [2:0] {IDLE, MUL_F, MUL_I, MUL_O, DONE} state_t;

  localparam logic [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINW = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] MAX2 = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] MIN2 = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [WIDTH-1:0] f_q, i_q, g_q, o_q;
  logic [WIDTH-1:0] c_reg, c_prev, h_reg, p_reg;
  logic [WIDTH-1:0] tanh_c;

  logic signed [WIDTH-1:0]   mul_a, mul_b;
  logic signed [2*WIDTH-1:0] prod, prod_sh;
  logic [WIDTH-1:0]          mul_sat, add_sat;
  logic [WIDTH:0]            sum;

  lstm_tanh #(.WIDTH(WIDTH), .FRAC(FRAC)) u_tanh (.x(c_reg), .y(tanh_c));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = MUL_F;
      MUL_F:   state_nxt = MUL_I;
      MUL_I:   state_nxt = MUL_O;
      MUL_O:   state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shared multiplier operand select
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_F:   begin mul_a = f_q; mul_b = c_reg;  end
      MUL_I:   begin mul_a = i_q; mul_b = g_q;    end
      MUL_O:   begin mul_a = o_q; mul_b = tanh_c; end
      default: ;
    endcase
  end

  always_comb begin
    prod    = mul_a * mul_b;
    prod_sh = prod >>> FRAC;
    if (prod_sh > MAX2)      mul_sat = MAXW;
    else if (prod_sh < MIN2) mul_sat = MINW;
    else                     mul_sat = prod_sh[WIDTH-1:0];
    sum = {p_reg[WIDTH-1], p_reg} + {mul_sat[WIDTH-1], mul_sat};
    if (sum[WIDTH] != sum[WIDTH-1]) add_sat = sum[WIDTH] ? MINW : MAXW;
    else                            add_sat = sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q    <= '0;
      i_q    <= '0;
      g_q    <= '0;
      o_q    <= '0;
      c_reg  <= '0;
      c_prev <= '0;
      h_reg  <= '0;
      p_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Clearing and accepting together makes this step start from c_{t-1}=0
          if (i_clr) c_reg <= '0;
          if (i_valid) begin
            f_q <= i_f;
            i_q <= i_i;
            g_q <= i_g;
            o_q <= i_o;
          end
        end
        MUL_F: p_reg <= mul_sat;
        MUL_I: begin
          c_prev <= c_reg;
          c_reg  <= add_sat;
        end
        MUL_O: h_reg <= mul_sat;
        default: ;
      endcase
    end
  end

  assign o_ready   = (state == IDLE);
  assign o_valid   = (state == DONE);
  assign o_c       = c_reg;
  assign o_c_prev  = c_prev;
  assign o_h       = h_reg;
  assign dbg_state = state;
endmodule

// File: tb/tb_lstm_cell_state.sv
// Directed bench for lstm_cell_state: arithmetic model of the cell update, per-cycle
// output compare against an expected queue, plus literal checks of key results.
module tb_lstm_cell_state;
  localparam int W    = 32;
  localparam int FRAC = 24;

  logic         clk = 1'b0;
  logic         rst, i_clr, i_valid, i_ready;
  logic [W-1:0] i_f, i_i, i_g, i_o;
  logic         o_ready, o_valid;
  logic [W-1:0] o_h, o_c, o_c_prev;
  logic [2:0]   dbg_state;

  lstm_cell_state #(.WIDTH(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_valid(i_valid), .o_ready(o_ready),
    .i_f(i_f), .i_i(i_i), .i_g(i_g), .i_o(i_o), .o_valid(o_valid), .i_ready(i_ready),
    .o_h(o_h), .o_c(o_c), .o_c_prev(o_c_prev), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_c_q[$];
  logic [W-1:0] exp_cp_q[$];
  logic [W-1:0] exp_h_q[$];
  logic [W-1:0] m_c;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model arithmetic: real-valued rules expressed in 64-bit integers
  function automatic logic [W-1:0] sat(input longint v);
    if (v > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (v < -64'sd2147483648) return 32'h80000000;
    return W'(v);
  endfunction

  function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return sat(p >>> FRAC);
  endfunction

  function automatic logic [W-1:0] tanh_model(input logic [W-1:0] x);
    longint one, v, a, y;
    one = 64'sd1 << FRAC;
    v = longint'($signed(x));
    a = (v < 0) ? -v : v;
    if (a < one / 2)            y = a;
    else if (a < one * 5 / 4)   y = a / 2 + one / 4;
    else if (a < one * 9 / 4)   y = a / 8 + one * 23 / 32;
    else                        y = one;
    return W'((v < 0) ? -y : y);
  endfunction

  task automatic model_step(input logic clr, input logic [W-1:0] f, i, g, o);
    logic [W-1:0] nc;
    if (clr) m_c = '0;
    nc = sat(longint'($signed(qmul(f, m_c))) + longint'($signed(qmul(i, g))));
    exp_cp_q.push_back(m_c);
    exp_c_q.push_back(nc);
    exp_h_q.push_back(qmul(o, tanh_model(nc)));
    m_c = nc;
  endtask

  task automatic flush_model();
    exp_c_q.delete();
    exp_cp_q.delete();
    exp_h_q.delete();
  endtask

  // Compare process: every cycle the outputs are offered they must match the model
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (exp_c_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got o_valid=1, expected no pending result at %0t", $time);
      end else begin
        check("o_c", o_c, exp_c_q[0]);
        check("o_c_prev", o_c_prev, exp_cp_q[0]);
        check("o_h", o_h, exp_h_q[0]);
        check("o_ready_busy", W'(o_ready), W'(0));
        if (i_ready) begin
          void'(exp_c_q.pop_front());
          void'(exp_cp_q.pop_front());
          void'(exp_h_q.pop_front());
        end
      end
    end
  end

  task automatic drive_accept(input logic clr, input logic [W-1:0] f, i, g, o, output bit ok);
    ok = 1'b0;
    i_clr = clr; i_f = f; i_i = i; i_g = g; i_o = o; i_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (o_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_clr = 1'b0;
    i_f = $urandom; i_i = $urandom; i_g = $urandom; i_o = $urandom;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got o_ready=0 for 20 cycles, expected 1");
    end
  endtask

  task automatic do_step(input logic clr, input logic [W-1:0] f, i, g, o, input int bp);
    bit ok;
    int cnt;
    drive_accept(clr, f, i, g, o, ok);
    if (!ok) return;
    model_step(clr, f, i, g, o);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!o_valid && cnt < 20);
    check("latency", W'(cnt), W'(4));
    if (!o_valid) begin
      flush_model();
      return;
    end
    if (bp > 0) begin
      for (int k = 0; k < bp; k++) begin
        @(posedge clk); #1;
        i_valid = 1'($urandom_range(0, 1));
        i_clr   = 1'($urandom_range(0, 1));
        i_f = $urandom; i_i = $urandom; i_g = $urandom; i_o = $urandom;
      end
      @(posedge clk); #1;
      i_valid = 1'b0; i_clr = 1'b0; i_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  logic [W-1:0] tv_f[4] = '{32'h00C00000, 32'hFF000000, 32'h7FFFFFFF, 32'h00000001};
  logic [W-1:0] tv_i[4] = '{32'h00400000, 32'h01000000, 32'h7FFFFFFF, 32'hFF400000};
  logic [W-1:0] tv_g[4] = '{32'hFF800000, 32'h00000001, 32'h7FFFFFFF, 32'h01800000};
  logic [W-1:0] tv_o[4] = '{32'h00800000, 32'h01000000, 32'h80000000, 32'h00C00000};

  initial begin
    bit ok;
    rst = 1'b0; i_clr = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_f = '0; i_i = '0; i_g = '0; i_o = '0;
    m_c = '0;
    #1 rst = 1'b1;
    #12;
    check("rst_o_valid", W'(o_valid), W'(0));
    check("rst_o_ready", W'(o_ready), W'(1));
    check("rst_o_h", o_h, 32'h0);
    check("rst_o_c", o_c, 32'h0);
    check("rst_o_c_prev", o_c_prev, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // c = 0.5*0 + 0.5*0.5 = 0.25; tanh(0.25) = 0.25
    do_step(1'b1, 32'h00800000, 32'h00800000, 32'h00800000, 32'h01000000, 0);
    check("s1_c", o_c, 32'h00400000);
    check("s1_c_prev", o_c_prev, 32'h00000000);
    check("s1_h", o_h, 32'h00400000);

    // c = 0.25 + 0.5 = 0.75; tanh(0.75) = 0.625
    do_step(1'b0, 32'h01000000, 32'h01000000, 32'h00800000, 32'h01000000, 0);
    check("s2_c", o_c, 32'h00C00000);
    check("s2_c_prev", o_c_prev, 32'h00400000);
    check("s2_h", o_h, 32'h00A00000);

    // Positive saturation
    do_step(1'b1, 32'h00000000, 32'h01000000, 32'h7F000000, 32'h01000000, 0);
    check("sat_build", o_c, 32'h7F000000);
    do_step(1'b0, 32'h01000000, 32'h01000000, 32'h00FFFFFF, 32'h01000000, 0);
    check("sat_edge", o_c, 32'h7FFFFFFF);
    do_step(1'b0, 32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000, 0);
    check("sat_pos", o_c, 32'h7FFFFFFF);
    check("sat_pos_h", o_h, 32'h01000000);

    // Negative mirror
    do_step(1'b1, 32'h00000000, 32'h01000000, 32'h81000000, 32'h01000000, 0);
    do_step(1'b0, 32'h01000000, 32'h01000000, 32'hFF000000, 32'h01000000, 0);
    check("sat_neg_edge", o_c, 32'h80000000);
    do_step(1'b0, 32'h01000000, 32'h01000000, 32'hFF000000, 32'h01000000, 0);
    check("sat_neg", o_c, 32'h80000000);
    check("sat_neg_h", o_h, 32'hFF000000);

    // Backpressure with noisy inputs, then a step proving c survived
    do_step(1'b1, 32'h00800000, 32'h01000000, 32'h00400000, 32'h01000000, 0);
    i_ready = 1'b0;
    do_step(1'b0, 32'h01000000, 32'h01000000, 32'h00400000, 32'h01000000, 10);
    check("bp_c", o_c, 32'h00800000);
    do_step(1'b0, 32'h01000000, 32'h00000000, 32'h00000000, 32'h01000000, 0);
    check("bp_after_c", o_c, 32'h00800000);

    // Reset during MUL_I discards the step
    drive_accept(1'b0, 32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000, ok);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    flush_model();
    m_c = '0;
    check("rmid_o_c", o_c, 32'h0);
    check("rmid_o_c_prev", o_c_prev, 32'h0);
    check("rmid_o_h", o_h, 32'h0);
    check("rmid_o_valid", W'(o_valid), W'(0));
    check("rmid_o_ready", W'(o_ready), W'(1));
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    do_step(1'b0, 32'h00000000, 32'h01000000, 32'h01000000, 32'h01000000, 0);
    check("rmid_next_c", o_c, 32'h01000000);
    check("rmid_next_c_prev", o_c_prev, 32'h0);
    check("rmid_next_h", o_h, 32'h00C00000);

    // Mixed-sign and product-saturation vectors, model-checked only
    for (int k = 0; k < 4; k++) do_step(1'b0, tv_f[k], tv_i[k], tv_g[k], tv_o[k], 0);

    repeat (3) @(posedge clk);
    if (exp_c_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL pending_results: got %0d unconsumed, expected 0", exp_c_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
